parking_ctrl: RTL

- Occupancy and barrier-gate controller for the parking lot.
- Consumes the one-cycle "car passed" pulses from the entry and exit direction detectors and the pending-car requests from the entry and exit loops.
- Shares the single barrier gate between the entry and exit lanes. Tracks occupancy against a capacity limit and flags protocol errors.

---
 rtl/parking_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/parking_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : parking_ctrl
// Description : Occupancy and barrier-gate controller for a parking lot.
//               Arbitrates one barrier gate between the entry and exit lanes,
//               keeps an occupancy count bounded by CAPACITY and flags pass
//               events that arrive outside their lane's gate window.
//
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous, active-high reset
//               req_in     - car waiting at the entry loop (level)
//               req_out    - car waiting at the exit loop (level)
//               car_in     - one-cycle pulse, a car has fully entered
//               car_out    - one-cycle pulse, a car has fully left
//               gate_open  - barrier open command
//               grant_in   - entry lane owns the gate
//               grant_out  - exit lane owns the gate
//               count      - current occupancy [CNT_W]
//               full       - count == CAPACITY
//               empty      - count == 0
//               err        - one-cycle pulse on an ignored/illegal pass event
//
// Build option: PARK_EXIT_PRIO_EN - when defined, the exit lane always wins
//               a tie in IDLE; otherwise ties are broken round-robin.
//
// Revision    : 1.0 - initial release
// ============================================================================
module parking_ctrl #(
    parameter int CAPACITY    = 16,
    parameter int CNT_W       = 5,
    parameter int OPEN_CYCLES = 8,
    parameter int TMR_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_in,
    input  logic             req_out,
    input  logic             car_in,
    input  logic             car_out,
    output logic             gate_open,
    output logic             grant_in,
    output logic             grant_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_OPEN_IN  = 2'd1;
    localparam logic [1:0] c_OPEN_OUT = 2'd2;
    localparam logic [1:0] c_CLOSE    = 2'd3;

    localparam logic [CNT_W-1:0] c_CAP       = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] c_TMR_LOAD  = TMR_W'(OPEN_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [TMR_W-1:0] r_timer;
    logic             r_last_out;   // 1: exit lane was served last
    logic             r_full;
    logic             r_empty;
    logic             r_err;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_last_out_nxt;
    logic             w_elig_in;
    logic             w_elig_out;
    logic             w_pick_in;
    logic             w_pick_out;
    logic             w_err;

    // Eligibility uses the registered flags so a full lot never admits and
    // an empty lot never opens for exit; this is what keeps count in range.
    assign w_elig_in  = req_in  && !r_full;
    assign w_elig_out = req_out && !r_empty;

`ifdef PARK_EXIT_PRIO_EN
    assign w_pick_in  = w_elig_in && !w_elig_out;
`else
    // On a tie, serve the lane opposite the one served last.
    assign w_pick_in  = w_elig_in && (!w_elig_out || r_last_out);
`endif
    assign w_pick_out = w_elig_out && !w_pick_in;

    // A pass pulse is only legal for the lane currently holding the gate.
    // This also covers simultaneous car_in/car_out inside a window: the
    // non-matching pulse is out of its window and raises err.
    assign w_err = (car_in  && (r_state != c_OPEN_IN)) ||
                   (car_out && (r_state != c_OPEN_OUT));

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_timer_nxt    = r_timer;
        w_last_out_nxt = r_last_out;
        case (r_state)
            c_IDLE: begin
                if (w_pick_in) begin
                    w_state_nxt    = c_OPEN_IN;
                    w_timer_nxt    = c_TMR_LOAD;
                    w_last_out_nxt = 1'b0;
                end else if (w_pick_out) begin
                    w_state_nxt    = c_OPEN_OUT;
                    w_timer_nxt    = c_TMR_LOAD;
                    w_last_out_nxt = 1'b1;
                end
            end
            c_OPEN_IN: begin
                // A pass in the final (timer==0) cycle still counts.
                if (car_in) begin
                    w_count_nxt = r_count + 1'b1;
                    w_state_nxt = c_CLOSE;
                    w_timer_nxt = '0;
                end else if (r_timer == '0) begin
                    w_state_nxt = c_CLOSE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            c_OPEN_OUT: begin
                if (car_out) begin
                    w_count_nxt = r_count - 1'b1;
                    w_state_nxt = c_CLOSE;
                    w_timer_nxt = '0;
                end else if (r_timer == '0) begin
                    w_state_nxt = c_CLOSE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            c_CLOSE: begin
                w_state_nxt = c_IDLE;
                w_timer_nxt = '0;
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_count    <= '0;
            r_timer    <= '0;
            r_last_out <= 1'b1;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_timer    <= w_timer_nxt;
            r_last_out <= w_last_out_nxt;
            // Flags are computed from the next count so they line up with
            // the updated count in the same cycle.
            r_full     <= (w_count_nxt == c_CAP);
            r_empty    <= (w_count_nxt == '0);
            r_err      <= w_err;
        end
    end

    assign gate_open = (r_state == c_OPEN_IN) || (r_state == c_OPEN_OUT);
    assign grant_in  = (r_state == c_OPEN_IN);
    assign grant_out = (r_state == c_OPEN_OUT);
    assign count     = r_count;
    assign full      = r_full;
    assign empty     = r_empty;
    assign err       = r_err;

endmodule
`default_nettype wire
